nibble_addsub_seq: RTL and testbench

NIBBLE_ADDSUB_SEQ -- requirements
Module: nibble_addsub_seq

---
 rtl/fas_pkg.sv | 13 +
 rtl/fasrip.sv | 30 +++
 rtl/nibble_addsub_seq.sv | 162 ++++++++++++++++
 tb/tb_nibble_addsub_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared definitions for the nibble-serial add/subtract datapath:
// the slice width and the control FSM state encoding.
package fas_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fasrip.sv
// 4-bit ripple-carry add/subtract slice.
// Subtract is a + ~b + cin; the caller seeds cin with 1 on the first nibble.
module fasrip
    import fas_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0]   c;
    logic [NIB_W-1:0] bx;

    assign bx   = b ^ {NIB_W{sub}};
    assign c[0] = cin;

    // One full adder per bit, carry rippling upward
    generate
        for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
            assign sum[gi]  = a[gi] ^ bx[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & bx[gi]) | (a[gi] & c[gi]) | (bx[gi] & c[gi]);
        end
    endgenerate

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_addsub_seq.sv
// Nibble-serial adder/subtractor: one 4-bit slice processes the operands
// LSB nibble first, one nibble per cycle, with a valid/ready handshake on
// both sides. Result and flags are held in DONE until consumed.
module nibble_addsub_seq
    import fas_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIBS = WIDTH / NIB_W;
    localparam int KW   = $clog2(NIBS);
    localparam int MSB  = WIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBS - 1);

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              op_q, op_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [NIB_W-1:0]  a_nib [NIBS];
    logic [NIB_W-1:0]  b_nib [NIBS];
    logic [NIB_W-1:0]  slice_sum;
    logic              slice_cout;
    logic [WIDTH-1:0]  s_run;

    // Split captured operands into nibbles and splice the slice result
    // into the currently addressed nibble of the result
    generate
        for (genvar gi = 0; gi < NIBS; gi++) begin : g_nib
            localparam logic [KW-1:0] IDX = KW'(gi);
            assign a_nib[gi] = a_q[gi*NIB_W +: NIB_W];
            assign b_nib[gi] = b_q[gi*NIB_W +: NIB_W];
            assign s_run[gi*NIB_W +: NIB_W] = (k_q == IDX) ? slice_sum
                                                            : s_q[gi*NIB_W +: NIB_W];
        end
    endgenerate

    fasrip u_slice (
        .a    (a_nib[k_q]),
        .b    (b_nib[k_q]),
        .sub  (op_q),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = s_op;
                    k_d        = '0;
                    carry_d    = s_op;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                s_d     = s_run;
                carry_d = slice_cout;
                zero_d  = (s_run == '0);
                if (k_q == K_LAST) begin
                    k_d         = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = slice_cout;
                    ovf_d       = (a_q[MSB] == (b_q[MSB] ^ op_q)) && (s_run[MSB] != a_q[MSB]);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Testbench for nibble_addsub_seq: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_nibble_addsub_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    nibble_addsub_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s_op      (s_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop,
                         output logic [W-1:0] es, output logic ec,
                         output logic eo, output logic ez);
        longint ua, ub, sa, sb, ures, sres;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = ma[W-1] ? ua - (longint'(1) << W) : ua;
        sb = mb[W-1] ? ub - (longint'(1) << W) : ub;
        if (mop) begin
            ures = ua - ub;
            sres = sa - sb;
            ec   = (ua >= ub);
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            ec   = (ures >= (longint'(1) << W));
        end
        es = W'(ures);
        eo = (sres > (longint'(1) << (W-1)) - 1) || (sres < -(longint'(1) << (W-1)));
        ez = (es == '0);
    endtask

    // One full transaction: accept, scramble inputs, measure latency,
    // check result, optionally stall consumer, then hand off.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic top, input int stall, input bit pulse_in_run);
        logic [W-1:0] es;
        logic         ec, eo, ez;
        int           lat;
        model(ta, tb_v, top, es, ec, eo, ez);
        @(negedge clk);
        chk({name, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb_v;
        s_op     = top;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        s_op     = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            if (pulse_in_run) in_valid = (lat == 1);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({name, ".latency"}, 64'(lat), 64'd4);
        chk({name, ".s"}, 64'(s), 64'(es));
        chk({name, ".cout"}, 64'(cout), 64'(ec));
        chk({name, ".ovf"}, 64'(ovf), 64'(eo));
        chk({name, ".zero"}, 64'(zero), 64'(ez));
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            @(negedge clk);
            chk({name, ".stall_valid"}, 64'(out_valid), 64'd1);
            chk({name, ".stall_in_ready"}, 64'(in_ready), 64'd0);
            chk({name, ".stall_s"}, {61'd0, cout, ovf, zero, 1'b0} | 64'(s) << 4,
                {61'd0, ec, eo, ez, 1'b0} | 64'(es) << 4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".released"}, 64'(out_valid), 64'd0);
        $display("op %s a=%h b=%h op=%0d -> s=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
                 name, ta, tb_v, top, s, cout, ovf, zero, lat);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        s_op      = 1'b0;
        #3;
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.s", 64'(s), 64'd0);
        chk("reset.zero", 64'(zero), 64'd1);
        chk("reset.cout_ovf", {62'd0, cout, ovf}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 0, 1'b0);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 0, 1'b0);
        run_op("sub_zero",  16'h1234, 16'h1234, 1'b1, 0, 1'b0);
        run_op("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op("ovf_sub",   16'h8000, 16'h0001, 1'b1, 0, 1'b0);
        run_op("wrap",      16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op("stall",     16'hA5A5, 16'h5A5B, 1'b0, 3, 1'b1);
        run_op("after",     16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        // Reset in the second RUN cycle drops the operation
        @(negedge clk);
        a        = 16'h4444;
        b        = 16'h1111;
        s_op     = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.s", 64'(s), 64'd0);
        chk("midrst.flags", {61'd0, cout, ovf, zero}, 64'd1);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst.no_result", 64'(out_valid), 64'd0);
        end
        run_op("post_rst", 16'h0100, 16'h00FF, 1'b0, 0, 1'b0);

        // Randomized operations with random consumer stalls
        for (int n = 0; n < 24; n++) begin
            run_op($sformatf("rnd%0d", n), W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
